// File: rtl/npc_pkg_ysyx.sv
// Shared definitions for the NPC multi-cycle sequencer: state encoding and the
// ebreak instruction word.
package npc_pkg_ysyx;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_FETCH = 4'd1;
    localparam logic [3:0] ST_FWAIT = 4'd2;
    localparam logic [3:0] ST_DEC   = 4'd3;
    localparam logic [3:0] ST_EXEC  = 4'd4;
    localparam logic [3:0] ST_MEM   = 4'd5;
    localparam logic [3:0] ST_MWAIT = 4'd6;
    localparam logic [3:0] ST_WB    = 4'd7;
    localparam logic [3:0] ST_HALT  = 4'd8;
    localparam logic [3:0] ST_ERR   = 4'd9;

    typedef enum logic [3:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_FWAIT = ST_FWAIT,
        S_DEC   = ST_DEC,
        S_EXEC  = ST_EXEC,
        S_MEM   = ST_MEM,
        S_MWAIT = ST_MWAIT,
        S_WB    = ST_WB,
        S_HALT  = ST_HALT,
        S_ERR   = ST_ERR
    } seqState_e;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

    // States in which the sequencer is waiting on a memory handshake.
    function automatic logic isWaitState(input seqState_e s);
        return (s == S_FETCH) || (s == S_FWAIT) || (s == S_MEM) || (s == S_MWAIT);
    endfunction

endpackage

// File: rtl/bus_timer_ysyx.sv
// Bus-wait watchdog: counts cycles spent waiting on a memory handshake and
// flags the cycle in which the TO_MAX-th wait cycle elapses.
module bus_timer_ysyx #(
    parameter int TO_W   = 8,
    parameter int TO_MAX = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt;

    // Wait counter; a clear (state change) takes precedence over counting.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the number of earlier wait cycles, so this is the TO_MAX-th one.
    assign expired = en && (cnt == TO_W'(TO_MAX - 1));

endmodule

// File: rtl/cpu_seq_ctrl_ysyx.sv
// Multi-cycle sequencer for the NPC core: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives the per-phase strobes, watches for bus
// hangs and counts retired instructions.
module cpu_seq_ctrl_ysyx
    import npc_pkg_ysyx::*;
#(
    parameter int TO_W   = 8,
    parameter int TO_MAX = 200
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    output logic        ir_we,
    input  logic        dec_regwr,
    input  logic        dec_memtoreg,
    input  logic        dec_memwr,
    input  logic        dec_ebreak,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    output logic        rf_we,
    output logic        pc_we,
    output logic        halt,
    output logic        bus_err,
    output logic [31:0] instret
);

    seqState_e state, nextState;
    logic      toExpired;
    logic      retire;

    bus_timer_ysyx #(
        .TO_W   (TO_W),
        .TO_MAX (TO_MAX)
    ) uTimer (
        .clk     (clk),
        .rst     (rst),
        .clr     (nextState != state),
        .en      (isWaitState(state)),
        .expired (toExpired)
    );

    // WB retires normally; the ebreak itself retires on the way into HALT.
    assign retire = (state == S_WB) || ((state == S_EXEC) && (nextState == S_HALT));

    // State register and the sticky status / retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            instret <= '0;
            halt    <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state <= nextState;
            if (retire) instret <= instret + 32'd1;
            if (nextState == S_HALT) halt <= 1'b1;
            if (nextState == S_ERR) bus_err <= 1'b1;
        end
    end

    // Next-state and strobe decode; a handshake in the expiry cycle still wins.
    always_comb begin
        nextState = state;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        unique case (state)
            S_IDLE: nextState = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    if (imem_rvalid) begin
                        ir_we     = 1'b1;
                        nextState = S_DEC;
                    end else begin
                        nextState = S_FWAIT;
                    end
                end else if (toExpired) begin
                    nextState = S_ERR;
                end
            end
            S_FWAIT: begin
                if (imem_rvalid) begin
                    ir_we     = 1'b1;
                    nextState = S_DEC;
                end else if (toExpired) begin
                    nextState = S_ERR;
                end
            end
            S_DEC: nextState = S_EXEC;
            S_EXEC: begin
                if (dec_ebreak)                      nextState = S_HALT;
                else if (dec_memtoreg && dec_memwr)  nextState = S_ERR;
                else if (dec_memtoreg || dec_memwr)  nextState = S_MEM;
                else                                 nextState = S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_memwr;
                if (dmem_gnt) begin
                    // Stores need no response; loads may get data with the grant.
                    if (dec_memwr || dmem_rvalid) nextState = S_WB;
                    else                          nextState = S_MWAIT;
                end else if (toExpired) begin
                    nextState = S_ERR;
                end
            end
            S_MWAIT: begin
                if (dmem_rvalid)    nextState = S_WB;
                else if (toExpired) nextState = S_ERR;
            end
            S_WB: begin
                rf_we     = dec_regwr;
                pc_we     = 1'b1;
                nextState = S_FETCH;
            end
            S_HALT: nextState = S_HALT;
            S_ERR:  nextState = S_ERR;
            default: nextState = S_ERR;
        endcase
    end

endmodule
